// File: rtl/ascent_integrator.sv
// ascent_integrator
//
// Sequences the three Saturn V burns, with a one-tick separation coast after
// each of the first two. Once per clock it integrates the net acceleration into
// a signed vertical velocity and an unsigned height using semi-implicit Euler.
// It also flags the 30 km crossing and ground contact. The gimbal stage
// consumes velocity and height directly.
//
// Units: velocity in 1e-9 m/tick, height in 1e-9 m, acceleration in 1e-9 m/tick^2.
//
// Ports:
//   clk      - system clock, rising edge
//   resetb   - asynchronous active-low reset
//   launch   - start request, only looked at while idle
//   abort    - cut thrust, looked at during the burn and separation phases
//   velocity - signed two's-complement vertical velocity (N bits)
//   height   - unsigned altitude (N bits), saturating at 2^N-1
//   stage    - phase code: IDLE=0 BURN1=1 SEP1=2 BURN2=3 SEP2=4 BURN3=5
//              COAST=6 LANDED=7
//   alt30    - registered flag, height above ALT_THRESH
//   landed   - high once the vehicle has touched down (terminal until reset)

module ascent_integrator #(
    parameter int              N            = 64,
    parameter int unsigned     STAGE1_TICKS = 150,
    parameter int unsigned     STAGE2_TICKS = 360,
    parameter int unsigned     STAGE3_TICKS = 500,
    parameter logic [N-1:0]    ACC1         = N'(30),
    parameter logic [N-1:0]    ACC2         = N'(20),
    parameter logic [N-1:0]    ACC3         = N'(15),
    parameter logic [N-1:0]    GRAVITY      = N'(10),
    parameter logic [N-1:0]    ALT_THRESH   = N'(64'd30000000000000)
) (
    input  logic         clk,
    input  logic         resetb,
    input  logic         launch,
    input  logic         abort,
    output logic [N-1:0] velocity,
    output logic [N-1:0] height,
    output logic [2:0]   stage,
    output logic         alt30,
    output logic         landed
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        BURN1  = 3'd1,
        SEP1   = 3'd2,
        BURN2  = 3'd3,
        SEP2   = 3'd4,
        BURN3  = 3'd5,
        COAST  = 3'd6,
        LANDED = 3'd7
    } state_t;

    // The burn counter is loaded with length-1 so that the edge on which it
    // reads zero is the last thrusting edge; each burn integrates exactly
    // STAGEk_TICKS times.
    localparam logic [31:0] RELOAD1 = 32'(STAGE1_TICKS - 1);
    localparam logic [31:0] RELOAD2 = 32'(STAGE2_TICKS - 1);
    localparam logic [31:0] RELOAD3 = 32'(STAGE3_TICKS - 1);

    // Saturation limits for velocity, expressed in the widened N+2 bit domain.
    localparam logic signed [N+1:0] V_MAX = {3'b000, {(N-1){1'b1}}};
    localparam logic signed [N+1:0] V_MIN = {3'b111, {(N-1){1'b0}}};

    state_t              state;
    state_t              state_next;
    logic [31:0]         count;
    logic [31:0]         count_next;
    logic [N-1:0]        velocity_next;
    logic [N-1:0]        height_next;
    logic                alt30_next;

    logic [N-1:0]        thrust;
    logic signed [N+1:0] accel;
    logic signed [N+1:0] v_sum;
    logic [N-1:0]        v_next;
    logic signed [N+1:0] h_calc;
    logic                ground;
    logic                h_over;

    // Thrust is only present in the burn phases and is cut on the very edge
    // that abort is seen, so an aborting edge already integrates gravity only.
    always_comb begin
        thrust = '0;
        if (!abort) begin
            case (state)
                BURN1:   thrust = ACC1;
                BURN2:   thrust = ACC2;
                BURN3:   thrust = ACC3;
                default: thrust = '0;
            endcase
        end
    end

    // Integration datapath. Everything is widened to N+2 signed bits so that
    // neither the velocity sum nor the height sum can wrap before it is
    // clamped. Height uses the freshly updated velocity (semi-implicit Euler).
    always_comb begin
        accel  = $signed({2'b00, thrust}) - $signed({2'b00, GRAVITY});
        v_sum  = $signed({{2{velocity[N-1]}}, velocity}) + accel;
        v_next = v_sum[N-1:0];
        if (v_sum > V_MAX) begin
            v_next = V_MAX[N-1:0];
        end else if (v_sum < V_MIN) begin
            v_next = V_MIN[N-1:0];
        end
        h_calc = $signed({2'b00, height}) + $signed({{2{v_next[N-1]}}, v_next});
        // Non-positive result means the vehicle has reached the ground.
        ground = h_calc[N+1] || (h_calc == '0);
        // Positive and beyond N bits means the unsigned height must saturate.
        h_over = !h_calc[N+1] && h_calc[N];
    end

    // Next-state, counter and integration results. Ground contact is checked
    // first so it overrides abort and counter expiry on the same edge.
    always_comb begin
        state_next    = state;
        count_next    = count;
        velocity_next = velocity;
        height_next   = height;

        case (state)
            IDLE: begin
                if (launch) begin
                    state_next = BURN1;
                    count_next = RELOAD1;
                end
            end

            LANDED: begin
                velocity_next = '0;
                height_next   = '0;
            end

            default: begin
                if (ground) begin
                    velocity_next = '0;
                    height_next   = '0;
                    state_next    = LANDED;
                    count_next    = '0;
                end else begin
                    velocity_next = v_next;
                    height_next   = h_over ? {N{1'b1}} : h_calc[N-1:0];

                    case (state)
                        BURN1, BURN2, BURN3: begin
                            if (abort) begin
                                state_next = COAST;
                                count_next = '0;
                            end else if (count == '0) begin
                                case (state)
                                    BURN1:   state_next = SEP1;
                                    BURN2:   state_next = SEP2;
                                    default: state_next = COAST;
                                endcase
                            end else begin
                                count_next = count - 32'd1;
                            end
                        end

                        SEP1: begin
                            if (abort) begin
                                state_next = COAST;
                            end else begin
                                state_next = BURN2;
                                count_next = RELOAD2;
                            end
                        end

                        SEP2: begin
                            if (abort) begin
                                state_next = COAST;
                            end else begin
                                state_next = BURN3;
                                count_next = RELOAD3;
                            end
                        end

                        default: begin
                            state_next = state;
                        end
                    endcase
                end
            end
        endcase
    end

    // The altitude flag is taken from the post-update height, so it lines up
    // with the height value it describes.
    always_comb begin
        alt30_next = (height_next > ALT_THRESH);
    end

    // State and datapath registers; reset aborts any flight immediately.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state    <= IDLE;
            count    <= '0;
            velocity <= '0;
            height   <= '0;
            alt30    <= 1'b0;
        end else begin
            state    <= state_next;
            count    <= count_next;
            velocity <= velocity_next;
            height   <= height_next;
            alt30    <= alt30_next;
        end
    end

    assign stage  = state;
    assign landed = (state == LANDED);

endmodule

// File: tb/tb_ascent_integrator.sv
// tb_ascent_integrator
//
// Bench for ascent_integrator using small burn lengths so that a whole
// flight fits in a few dozen clocks. A second instance with a weak first stage
// (thrust equal to gravity) covers the immediate-landing case. Random
// launch/abort/reset traffic is compared against a segment-schedule model.

module tb_ascent_integrator;

    localparam longint G_ACC   = 10;
    localparam longint THRESH  = 100;

    logic        clk;
    logic        resetb;
    logic        launch;
    logic        abort;
    logic [63:0] velocity;
    logic [63:0] height;
    logic [2:0]  stage;
    logic        alt30;
    logic        landed;

    logic        launch_w;
    logic        abort_w;
    logic [63:0] velocity_w;
    logic [63:0] height_w;
    logic [2:0]  stage_w;
    logic        alt30_w;
    logic        landed_w;

    int num_compared;
    int num_mismatched;

    ascent_integrator #(
        .N            (64),
        .STAGE1_TICKS (4),
        .STAGE2_TICKS (2),
        .STAGE3_TICKS (1),
        .ACC1         (64'd30),
        .ACC2         (64'd20),
        .ACC3         (64'd15),
        .GRAVITY      (64'd10),
        .ALT_THRESH   (64'd100)
    ) dut (
        .clk      (clk),
        .resetb   (resetb),
        .launch   (launch),
        .abort    (abort),
        .velocity (velocity),
        .height   (height),
        .stage    (stage),
        .alt30    (alt30),
        .landed   (landed)
    );

    ascent_integrator #(
        .N            (64),
        .STAGE1_TICKS (4),
        .ACC1         (64'd10),
        .GRAVITY      (64'd10),
        .ALT_THRESH   (64'd100)
    ) dut_weak (
        .clk      (clk),
        .resetb   (resetb),
        .launch   (launch_w),
        .abort    (abort_w),
        .velocity (velocity_w),
        .height   (height_w),
        .stage    (stage_w),
        .alt30    (alt30_w),
        .landed   (landed_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic   launch;
        logic   abort;
        longint exp_v;
        longint exp_h;
        int     exp_stage;
        logic   exp_alt30;
        logic   exp_landed;
    } vec_t;

    vec_t vecs [11];

    // Reference model: a flight is a fixed schedule of (acceleration, length)
    // segments followed by an open-ended coast. Progress is tracked as ticks
    // spent in the current segment.
    longint seg_acc [6];
    longint seg_len [5];
    int     m_phase;   // 0 idle, 1 flying, 2 landed
    int     m_seg;
    longint m_ticks;
    longint m_v;
    longint m_h;

    function automatic void modelReset();
        m_phase = 0;
        m_seg   = 0;
        m_ticks = 0;
        m_v     = 0;
        m_h     = 0;
    endfunction

    function automatic void modelStep(input logic l, input logic a);
        longint acc;
        if (m_phase == 0) begin
            if (l) begin
                m_phase = 1;
                m_seg   = 0;
                m_ticks = 0;
            end
        end else if (m_phase == 1) begin
            if (a && m_seg < 5) acc = -G_ACC;
            else acc = seg_acc[m_seg];
            m_v = m_v + acc;
            m_h = m_h + m_v;
            if (m_h <= 0) begin
                m_phase = 2;
                m_v     = 0;
                m_h     = 0;
            end else if (a && m_seg < 5) begin
                m_seg = 5;
            end else if (m_seg < 5) begin
                m_ticks = m_ticks + 1;
                if (m_ticks == seg_len[m_seg]) begin
                    m_seg   = m_seg + 1;
                    m_ticks = 0;
                end
            end
        end
    endfunction

    function automatic int modelStage();
        if (m_phase == 0) return 0;
        if (m_phase == 2) return 7;
        return m_seg + 1;
    endfunction

    task automatic compareOne(input string name, input string field,
                              input longint act, input longint exp);
        num_compared++;
        if (act != exp) begin
            num_mismatched++;
            $display("[TB] FAIL %s %s: got %0d, expected %0d", name, field, act, exp);
        end
    endtask

    task automatic checkOutput(input string name,
                               input logic [63:0] act_v, input logic [63:0] act_h,
                               input logic [2:0] act_s, input logic act_a,
                               input logic act_l,
                               input longint exp_v, input longint exp_h,
                               input int exp_s, input logic exp_a,
                               input logic exp_l);
        compareOne(name, "velocity", $signed(act_v), exp_v);
        compareOne(name, "height", longint'(act_h), exp_h);
        compareOne(name, "stage", longint'(act_s), longint'(exp_s));
        compareOne(name, "alt30", longint'(act_a), longint'(exp_a));
        compareOne(name, "landed", longint'(act_l), longint'(exp_l));
    endtask

    // Drive inputs well away from the edge, then sample 1 time unit after it.
    task automatic applyStimulus(input logic l, input logic a);
        launch = l;
        abort  = a;
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        resetb = 1'b0;
        launch = 1'b0;
        abort  = 1'b0;
        @(posedge clk);
        #1;
        resetb = 1'b1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        longint ev;
        longint eh;
        int     es;
        logic   el;
        logic   rl;
        logic   ra;
        bit     done;

        num_compared   = 0;
        num_mismatched = 0;

        seg_acc[0] = 30 - G_ACC;  seg_len[0] = 4;
        seg_acc[1] = -G_ACC;      seg_len[1] = 1;
        seg_acc[2] = 20 - G_ACC;  seg_len[2] = 2;
        seg_acc[3] = -G_ACC;      seg_len[3] = 1;
        seg_acc[4] = 15 - G_ACC;  seg_len[4] = 1;
        seg_acc[5] = -G_ACC;

        // Nominal profile: launch edge, four burn-1 edges, separation, burn 2,
        // separation, burn 3, first coast edge. Launch is re-asserted during
        // burn 1 and must be ignored. Height 120 is the first above 100.
        vecs[0]  = '{1'b1, 1'b0,  0,   0, 1, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 20,  20, 1, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 40,  60, 1, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 60, 120, 1, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 80, 200, 2, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 70, 270, 3, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 80, 350, 3, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 90, 440, 4, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 80, 520, 5, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 85, 605, 6, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 75, 680, 6, 1'b1, 1'b0};

        resetb   = 1'b0;
        launch   = 1'b1;
        abort    = 1'b0;
        launch_w = 1'b0;
        abort_w  = 1'b0;

        $display("[TB] reset held with launch asserted");
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset", velocity, height, stage, alt30, landed, 0, 0, 0, 1'b0, 1'b0);
        checkOutput("reset_weak", velocity_w, height_w, stage_w, alt30_w, landed_w,
                    0, 0, 0, 1'b0, 1'b0);
        resetb = 1'b1;
        launch = 1'b0;
        applyStimulus(1'b0, 1'b0);
        checkOutput("idle", velocity, height, stage, alt30, landed, 0, 0, 0, 1'b0, 1'b0);

        $display("[TB] nominal profile table");
        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i].launch, vecs[i].abort);
            checkOutput($sformatf("profile[%0d]", i), velocity, height, stage, alt30, landed,
                        vecs[i].exp_v, vecs[i].exp_h, vecs[i].exp_stage,
                        vecs[i].exp_alt30, vecs[i].exp_landed);
        end

        // Coast under gravity until the ground is reached.
        ev   = 75;
        eh   = 680;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            applyStimulus(1'b0, 1'b0);
            ev = ev - G_ACC;
            eh = eh + ev;
            es = 6;
            el = 1'b0;
            if (eh <= 0) begin
                ev   = 0;
                eh   = 0;
                es   = 7;
                el   = 1'b1;
                done = 1'b1;
            end
            checkOutput($sformatf("coast[%0d]", i), velocity, height, stage, alt30, landed,
                        ev, eh, es, (eh > THRESH), el);
        end
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 1'b1);
            checkOutput($sformatf("landed_hold[%0d]", i), velocity, height, stage, alt30,
                        landed, 0, 0, 7, 1'b0, 1'b1);
        end

        $display("[TB] asynchronous reset during burn 2");
        doReset();
        applyStimulus(1'b1, 1'b0);
        for (int i = 1; i <= 6; i++) applyStimulus(1'b0, 1'b0);
        checkOutput("pre_reset_burn2", velocity, height, stage, alt30, landed,
                    80, 350, 3, 1'b1, 1'b0);
        resetb = 1'b0;
        #2;
        checkOutput("async_reset", velocity, height, stage, alt30, landed,
                    0, 0, 0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        resetb = 1'b1;
        applyStimulus(1'b0, 1'b0);
        checkOutput("after_reset_idle", velocity, height, stage, alt30, landed,
                    0, 0, 0, 1'b0, 1'b0);

        $display("[TB] abort during burn 1");
        applyStimulus(1'b1, 1'b0);
        checkOutput("abort_launch", velocity, height, stage, alt30, landed, 0, 0, 1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("abort_e1", velocity, height, stage, alt30, landed, 20, 20, 1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1);
        checkOutput("abort_e2", velocity, height, stage, alt30, landed, 10, 30, 6, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("abort_e3", velocity, height, stage, alt30, landed, 0, 30, 6, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("abort_e4", velocity, height, stage, alt30, landed, -10, 20, 6, 1'b0, 1'b0);

        $display("[TB] weak first stage lands on first edge");
        doReset();
        launch_w = 1'b1;
        @(posedge clk);
        #1;
        launch_w = 1'b0;
        checkOutput("weak_launch", velocity_w, height_w, stage_w, alt30_w, landed_w,
                    0, 0, 1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("weak_landed", velocity_w, height_w, stage_w, alt30_w, landed_w,
                    0, 0, 7, 1'b0, 1'b1);

        $display("[TB] random launch/abort/reset traffic");
        doReset();
        modelReset();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                resetb = 1'b0;
                #1;
                modelReset();
                checkOutput($sformatf("rand_reset[%0d]", i), velocity, height, stage, alt30,
                            landed, 0, 0, 0, 1'b0, 1'b0);
                resetb = 1'b1;
            end else begin
                rl = ($urandom_range(0, 7) == 0);
                ra = ($urandom_range(0, 39) == 0);
                applyStimulus(rl, ra);
                modelStep(rl, ra);
                checkOutput($sformatf("rand[%0d]", i), velocity, height, stage, alt30, landed,
                            m_v, m_h, modelStage(), (m_h > THRESH), (m_phase == 2));
                // Start a fresh flight now and then once the vehicle has landed.
                if (m_phase == 2 && $urandom_range(0, 9) == 0) begin
                    doReset();
                    modelReset();
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
        $finish;
    end

endmodule
